// File: rtl/fetch_unit_pkg.sv
// -----------------------------------------------------------------------------
// fetch_unit_pkg
// Shared definitions for the instruction fetch slice of the single-cycle core:
// fetch FSM state encodings, the default NOP word injected on a fetch fault,
// the timeout counter width and a small PC alignment helper.
// Also provides the core-wide `BUS_WIDTH macro when nobody defined it earlier.
// -----------------------------------------------------------------------------
`ifndef BUS_WIDTH
`define BUS_WIDTH 32
`endif

package fetch_unit_pkg;

  // Fetch FSM states. IDLE samples the PC, REQ waits for memory, HOLD presents
  // the buffered instruction and DRAIN swallows the response of a flushed request.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } fetch_state_t;

  // addi x0, x0, 0 : handed to decode whenever a fetch cannot produce real data.
  localparam logic [31:0] DEFAULT_NOP_INSTR = 32'h0000_0013;

  // Wide enough for the largest supported timeout (255 cycles).
  localparam int unsigned TIMEOUT_CTR_WIDTH = 8;

  // A PC is fetchable only when it is word aligned.
  function automatic logic is_misaligned(input logic [1:0] pc_lsbs);
    return (pc_lsbs != 2'b00);
  endfunction

endpackage

// File: rtl/fetch_timeout_ctr.sv
// -----------------------------------------------------------------------------
// fetch_timeout_ctr
// Load/enable down-counter that measures how long a memory request has been
// waiting. Loaded with TIMEOUT_CYCLES-1 when a request window opens; counts
// down while enabled and raises o_terminal once it reaches zero.
//
// Ports:
//   i_clk       core clock
//   i_rst       synchronous active-high reset (count cleared to zero)
//   i_load      open a fresh timeout window
//   i_en        one more cycle elapsed without a response
//   o_terminal  the window is exhausted (count == 0)
// -----------------------------------------------------------------------------
module fetch_timeout_ctr
  import fetch_unit_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_load,
  input  logic i_en,
  output logic o_terminal
);

  localparam logic [TIMEOUT_CTR_WIDTH-1:0] LOAD_VALUE =
    TIMEOUT_CTR_WIDTH'(TIMEOUT_CYCLES - 1);

  logic [TIMEOUT_CTR_WIDTH-1:0] r_count;

  // Loading wins over counting so a new window always starts from the top.
  // The count saturates at zero so the terminal flag stays asserted.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= LOAD_VALUE;
    end else if (i_en && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_terminal = (r_count == '0);

endmodule

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Takes the current PC, issues a single word request to instruction memory and
// buffers the returned instruction until the decode/execute path consumes it.
// Misaligned PCs and timed-out requests are turned into a buffered NOP with a
// fault flag, so the core never hangs waiting for memory.
//
// Ports:
//   i_clk, i_rst      core clock, synchronous active-high reset
//   i_pc_addr         current PC from the PC register
//   i_flush           redirect: drop anything in flight or buffered
//   o_imem_req        request valid to instruction memory
//   o_imem_addr       word address of the request
//   i_imem_ack        single-cycle response strobe
//   i_imem_rdata      instruction word, valid with i_imem_ack
//   o_instr           buffered instruction
//   o_instr_addr      PC of the buffered instruction
//   o_instr_valid     o_instr / o_instr_addr are valid
//   i_instr_ready     consumer takes o_instr this cycle
//   o_pc_stall        PC register must hold (~(valid & ready))
//   o_misalign_fault  buffered instruction came from a misaligned PC
//   o_bus_error       buffered instruction came from a timed-out request
// -----------------------------------------------------------------------------
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int unsigned          BUS_WIDTH      = `BUS_WIDTH,
  parameter int unsigned          TIMEOUT_CYCLES = 16,
  parameter logic [BUS_WIDTH-1:0] NOP_INSTR      = BUS_WIDTH'(DEFAULT_NOP_INSTR)
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [BUS_WIDTH-1:0] i_pc_addr,
  input  logic                 i_flush,
  output logic                 o_imem_req,
  output logic [BUS_WIDTH-1:0] o_imem_addr,
  input  logic                 i_imem_ack,
  input  logic [BUS_WIDTH-1:0] i_imem_rdata,
  output logic [BUS_WIDTH-1:0] o_instr,
  output logic [BUS_WIDTH-1:0] o_instr_addr,
  output logic                 o_instr_valid,
  input  logic                 i_instr_ready,
  output logic                 o_pc_stall,
  output logic                 o_misalign_fault,
  output logic                 o_bus_error
);

  // Registered state and outputs.
  fetch_state_t         r_state;
  logic                 r_imem_req;
  logic [BUS_WIDTH-1:0] r_imem_addr;
  logic [BUS_WIDTH-1:0] r_instr;
  logic [BUS_WIDTH-1:0] r_instr_addr;
  logic                 r_instr_valid;
  logic                 r_misalign_fault;
  logic                 r_bus_error;

  // Next-state values and timeout counter controls.
  fetch_state_t         w_state_next;
  logic                 w_imem_req_next;
  logic [BUS_WIDTH-1:0] w_imem_addr_next;
  logic [BUS_WIDTH-1:0] w_instr_next;
  logic [BUS_WIDTH-1:0] w_instr_addr_next;
  logic                 w_instr_valid_next;
  logic                 w_misalign_fault_next;
  logic                 w_bus_error_next;
  logic                 w_ctr_load;
  logic                 w_ctr_en;
  logic                 w_ctr_terminal;

  // One counter covers both REQ and DRAIN; it is reloaded when either opens.
  fetch_timeout_ctr #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout_ctr (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_load     (w_ctr_load),
    .i_en       (w_ctr_en),
    .o_terminal (w_ctr_terminal)
  );

  // Next-state and next-output logic. Every field defaults to holding its
  // value so only the transitions below touch the buffer.
  always_comb begin
    w_state_next          = r_state;
    w_imem_req_next       = r_imem_req;
    w_imem_addr_next      = r_imem_addr;
    w_instr_next          = r_instr;
    w_instr_addr_next     = r_instr_addr;
    w_instr_valid_next    = r_instr_valid;
    w_misalign_fault_next = r_misalign_fault;
    w_bus_error_next      = r_bus_error;
    w_ctr_load            = 1'b0;
    w_ctr_en              = 1'b0;

    case (r_state)
      IDLE: begin
        if (!i_flush) begin
          if (!is_misaligned(i_pc_addr[1:0])) begin
            w_state_next     = REQ;
            w_imem_req_next  = 1'b1;
            w_imem_addr_next = i_pc_addr;
            w_ctr_load       = 1'b1;
          end else begin
            // A misaligned PC never reaches memory; decode sees a faulting NOP.
            w_state_next          = HOLD;
            w_instr_next          = NOP_INSTR;
            w_instr_addr_next     = i_pc_addr;
            w_instr_valid_next    = 1'b1;
            w_misalign_fault_next = 1'b1;
            w_bus_error_next      = 1'b0;
          end
        end
      end

      REQ: begin
        if (i_imem_ack) begin
          w_imem_req_next = 1'b0;
          if (i_flush) begin
            w_state_next = IDLE;
          end else begin
            w_state_next          = HOLD;
            w_instr_next          = i_imem_rdata;
            w_instr_addr_next     = r_imem_addr;
            w_instr_valid_next    = 1'b1;
            w_misalign_fault_next = 1'b0;
            w_bus_error_next      = 1'b0;
          end
        end else if (i_flush) begin
          // The request cannot be withdrawn, so keep it up and wait it out.
          w_state_next = DRAIN;
          w_ctr_load   = 1'b1;
        end else if (w_ctr_terminal) begin
          w_state_next          = HOLD;
          w_imem_req_next       = 1'b0;
          w_instr_next          = NOP_INSTR;
          w_instr_addr_next     = r_imem_addr;
          w_instr_valid_next    = 1'b1;
          w_misalign_fault_next = 1'b0;
          w_bus_error_next      = 1'b1;
        end else begin
          w_ctr_en = 1'b1;
        end
      end

      DRAIN: begin
        // Either the response or the timeout closes the dead request silently.
        if (i_imem_ack || w_ctr_terminal) begin
          w_state_next    = IDLE;
          w_imem_req_next = 1'b0;
        end else begin
          w_ctr_en = 1'b1;
        end
      end

      HOLD: begin
        // Flush and consume both release the buffer; flush needs no ready.
        if (i_flush || i_instr_ready) begin
          w_state_next          = IDLE;
          w_instr_valid_next    = 1'b0;
          w_misalign_fault_next = 1'b0;
          w_bus_error_next      = 1'b0;
        end
      end

      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // State and output registers; reset overrides every state and drops the
  // request on the very next edge.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state          <= IDLE;
      r_imem_req       <= 1'b0;
      r_imem_addr      <= '0;
      r_instr          <= NOP_INSTR;
      r_instr_addr     <= '0;
      r_instr_valid    <= 1'b0;
      r_misalign_fault <= 1'b0;
      r_bus_error      <= 1'b0;
    end else begin
      r_state          <= w_state_next;
      r_imem_req       <= w_imem_req_next;
      r_imem_addr      <= w_imem_addr_next;
      r_instr          <= w_instr_next;
      r_instr_addr     <= w_instr_addr_next;
      r_instr_valid    <= w_instr_valid_next;
      r_misalign_fault <= w_misalign_fault_next;
      r_bus_error      <= w_bus_error_next;
    end
  end

  assign o_imem_req       = r_imem_req;
  assign o_imem_addr      = r_imem_addr;
  assign o_instr          = r_instr;
  assign o_instr_addr     = r_instr_addr;
  assign o_instr_valid    = r_instr_valid;
  assign o_misalign_fault = r_misalign_fault;
  assign o_bus_error      = r_bus_error;

  // The PC may only advance on the cycle the buffered instruction is taken.
  assign o_pc_stall = ~(r_instr_valid & i_instr_ready);

endmodule
